// File: rtl/audio_engine_scheduler_pkg.sv
// Shared definitions for the audio engine scheduler: FSM state encoding and
// elaboration-time parameter legality check.
package audio_engine_scheduler_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_START = 2'd1;
    localparam logic [STATE_W-1:0] ST_WAIT  = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

    // Channel index must cover every channel and the timer must be able to reach TIMEOUT-1.
    function automatic bit params_legal(int num_ch, int ch_w, int timeout, int tmr_w);
        return (num_ch >= 1) && (ch_w >= 1) && ((1 << ch_w) >= num_ch) &&
               (timeout >= 2) && ((1 << tmr_w) > timeout);
    endfunction

endpackage

// File: rtl/audio_engine_scheduler_if.sv
// Frame-strobe, engine handshake and status bundle of the audio engine scheduler.
// master = scheduler side, slave = frame source / engine / status consumer side.
interface audio_engine_scheduler_if #(
    parameter int CH_W  = 1,
    parameter int OVR_W = 8
);
    logic             sample_en;
    logic             eng_done;
    logic             clear_err;
    logic             eng_start;
    logic [CH_W-1:0]  eng_ch;
    logic             busy;
    logic             frame_done;
    logic             overrun_err;
    logic             timeout_err;
    logic [OVR_W-1:0] overrun_cnt;

    modport master (
        input  sample_en, eng_done, clear_err,
        output eng_start, eng_ch, busy, frame_done, overrun_err, timeout_err, overrun_cnt
    );

    modport slave (
        output sample_en, eng_done, clear_err,
        input  eng_start, eng_ch, busy, frame_done, overrun_err, timeout_err, overrun_cnt
    );
endinterface

// File: rtl/sched_timeout_timer.sv
// Per-job watchdog: cleared when a job starts, counts while waiting, and
// flags expiry on the cycle the count reaches TIMEOUT-1.
module sched_timeout_timer #(
    parameter int TIMEOUT = 64,
    parameter int TMR_W   = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expire
);
    logic [TMR_W-1:0] timer;

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (count) begin
            timer <= timer + TMR_W'(1);
        end
    end

    assign expire = (timer == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/audio_engine_scheduler.sv
// Sequences one shared audio engine across NUM_CH channels per accepted frame
// strobe, with sticky overrun/timeout flags and a saturating overrun counter.
module audio_engine_scheduler
    import audio_engine_scheduler_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CH_W    = 1,
    parameter int TIMEOUT = 64,
    parameter int TMR_W   = 7,
    parameter int OVR_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    audio_engine_scheduler_if.master bus
);
    if (!params_legal(NUM_CH, CH_W, TIMEOUT, TMR_W)) begin : g_bad_params
        $error("audio_engine_scheduler: illegal NUM_CH/CH_W/TIMEOUT/TMR_W combination");
    end

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic [STATE_W-1:0] state, state_nxt;
    logic [CH_W-1:0]    ch, ch_nxt;
    logic               expire;
    logic               advance;
    logic               overrun_evt;
    logic               timeout_evt;
    logic               overrun_err;
    logic               timeout_err;
    logic [OVR_W-1:0]   overrun_cnt;

    sched_timeout_timer #(
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_START),
        .count  (state == ST_WAIT),
        .expire (expire)
    );

    // A done pulse coinciding with expiry counts as a normal completion.
    assign advance     = (state == ST_WAIT) && (bus.eng_done || expire);
    assign timeout_evt = (state == ST_WAIT) && !bus.eng_done && expire;
    assign overrun_evt = bus.sample_en && (state != ST_IDLE);

    // NOTE: defaults at the top of always_comb keep every path assigned, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        case (state)
            ST_IDLE: begin
                if (bus.sample_en) begin
                    state_nxt = ST_START;
                    ch_nxt    = '0;
                end
            end
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (advance) begin
                    if (ch == LAST_CH) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_START;
                        ch_nxt    = ch + CH_W'(1);
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ch    <= '0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
        end
    end

    // New error events take priority over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (overrun_evt) begin
                overrun_err <= 1'b1;
            end else if (bus.clear_err) begin
                overrun_err <= 1'b0;
            end

            if (timeout_evt) begin
                timeout_err <= 1'b1;
            end else if (bus.clear_err) begin
                timeout_err <= 1'b0;
            end

            if (bus.clear_err) begin
                overrun_cnt <= overrun_evt ? OVR_W'(1) : '0;
            end else if (overrun_evt && (overrun_cnt != '1)) begin
                overrun_cnt <= overrun_cnt + OVR_W'(1);
            end
        end
    end

    assign bus.eng_start   = (state == ST_START);
    assign bus.eng_ch      = ch;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.frame_done  = (state == ST_DONE);
    assign bus.overrun_err = overrun_err;
    assign bus.timeout_err = timeout_err;
    assign bus.overrun_cnt = overrun_cnt;

endmodule

// File: tb/tb_audio_engine_scheduler.sv
// Self-checking bench for audio_engine_scheduler: scoreboarded start/frame events
// plus a small error-flag model; a second instance with a 2-bit counter checks saturation.
module tb_audio_engine_scheduler;

    localparam int NUM_CH  = 2;
    localparam int CH_W    = 1;
    localparam int TIMEOUT = 64;
    localparam int TMR_W   = 7;
    localparam int OVR_W   = 8;
    localparam int SAT_W   = 2;
    localparam int OVR_MAX = (1 << OVR_W) - 1;
    localparam int SAT_MAX = (1 << SAT_W) - 1;

    typedef struct {
        int ch;
        int cyc;
    } start_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    start_t start_q[$];
    int     frame_q[$];

    int cnt_model  = 0;
    int cnt2_model = 0;
    bit err_model  = 1'b0;
    bit tmo_model  = 1'b0;

    audio_engine_scheduler_if #(.CH_W(CH_W), .OVR_W(OVR_W)) bus ();
    audio_engine_scheduler_if #(.CH_W(CH_W), .OVR_W(SAT_W)) bus_sat ();

    assign bus_sat.sample_en = bus.sample_en;
    assign bus_sat.eng_done  = bus.eng_done;
    assign bus_sat.clear_err = bus.clear_err;

    audio_engine_scheduler #(
        .NUM_CH (NUM_CH), .CH_W (CH_W), .TIMEOUT (TIMEOUT), .TMR_W (TMR_W), .OVR_W (OVR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    audio_engine_scheduler #(
        .NUM_CH (NUM_CH), .CH_W (CH_W), .TIMEOUT (TIMEOUT), .TMR_W (TMR_W), .OVR_W (SAT_W)
    ) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_drive(bit ovr, bit clr);
        if (ovr) err_model = 1'b1;
        else if (clr) err_model = 1'b0;
        if (clr) begin
            tmo_model  = 1'b0;
            cnt_model  = ovr ? 1 : 0;
            cnt2_model = ovr ? 1 : 0;
        end else if (ovr) begin
            if (cnt_model < OVR_MAX) cnt_model++;
            if (cnt2_model < SAT_MAX) cnt2_model++;
        end
    endfunction

    function automatic void model_reset();
        cnt_model  = 0;
        cnt2_model = 0;
        err_model  = 1'b0;
        tmo_model  = 1'b0;
        start_q.delete();
        frame_q.delete();
    endfunction

    // One frame: done_dly<0 means the engine never answers; overruns are pulsed
    // on cycles [ovr_first, ovr_first+n_ovr) and clear_err on cycle clr_cyc.
    task automatic run_frame(input string tag, input int done_dly, input int ovr_first,
                             input int n_ovr, input int clr_cyc);
        int     eff, len, budget, cyc, since, cur_ch, exp_len;
        bit     tmo_exp, seen_done, ovr, clr;
        start_t e;

        tmo_exp = (done_dly < 0) || (done_dly > TIMEOUT);
        eff     = tmo_exp ? TIMEOUT : done_dly;
        len     = NUM_CH * (1 + eff) + 1;
        for (int k = 0; k < NUM_CH; k++) begin
            e.ch  = k;
            e.cyc = 1 + k * (1 + eff);
            start_q.push_back(e);
        end
        frame_q.push_back(len);
        budget    = len + 20;
        since     = -1;
        cur_ch    = -1;
        seen_done = 1'b0;

        bus.sample_en = 1'b1;
        tick();
        cyc = 1;
        while (!seen_done && cyc <= budget) begin
            bus.sample_en = 1'b0;
            bus.eng_done  = 1'b0;
            bus.clear_err = 1'b0;

            n_checks++;
            if (bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy: cycle %0d got %b want 1", tag, cyc, bus.busy);
            end

            if (bus.eng_start === 1'b1) begin
                n_checks++;
                if (start_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s start: unexpected eng_start at cycle %0d ch %0d", tag, cyc, bus.eng_ch);
                end else begin
                    e = start_q.pop_front();
                    if (bus.eng_ch !== CH_W'(e.ch) || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL %s start: got ch %0d at cycle %0d, want ch %0d at cycle %0d",
                                 tag, bus.eng_ch, cyc, e.ch, e.cyc);
                    end
                    cur_ch = e.ch;
                    since  = 0;
                end
            end else begin
                if (since >= 0) since++;
                if (cur_ch >= 0) begin
                    n_checks++;
                    if (bus.eng_ch !== CH_W'(cur_ch)) begin
                        n_fail++;
                        $display("FAIL %s eng_ch_hold: cycle %0d got %0d want %0d", tag, cyc, bus.eng_ch, cur_ch);
                    end
                end
            end

            if (bus.frame_done === 1'b1) begin
                seen_done = 1'b1;
                n_checks++;
                if (frame_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s frame_done: unexpected at cycle %0d", tag, cyc);
                end else begin
                    exp_len = frame_q.pop_front();
                    if (cyc != exp_len) begin
                        n_fail++;
                        $display("FAIL %s frame_done: got cycle %0d want cycle %0d", tag, cyc, exp_len);
                    end
                end
                tmo_model = tmo_model | tmo_exp;
                n_checks++;
                if ({bus.overrun_err, bus.timeout_err, bus.overrun_cnt, bus_sat.overrun_cnt} !==
                    {err_model, tmo_model, OVR_W'(cnt_model), SAT_W'(cnt2_model)}) begin
                    n_fail++;
                    $display("FAIL %s errors_at_done: got ovr=%b tmo=%b cnt=%0d sat=%0d want ovr=%b tmo=%b cnt=%0d sat=%0d",
                             tag, bus.overrun_err, bus.timeout_err, bus.overrun_cnt, bus_sat.overrun_cnt,
                             err_model, tmo_model, cnt_model, cnt2_model);
                end
            end

            ovr = (cyc >= ovr_first) && (cyc < ovr_first + n_ovr);
            clr = (cyc == clr_cyc);
            if (done_dly >= 0 && since == done_dly) bus.eng_done = 1'b1;
            bus.sample_en = ovr;
            bus.clear_err = clr;
            model_drive(ovr, clr);
            tick();
            cyc++;
        end

        bus.sample_en = 1'b0;
        bus.eng_done  = 1'b0;
        bus.clear_err = 1'b0;

        if (!seen_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s frame_done: not seen within %0d cycles", tag, budget);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || start_q.size() != 0 || frame_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s idle_after: busy=%b frame_done=%b pending_starts=%0d pending_frames=%0d want 0 0 0 0",
                     tag, bus.busy, bus.frame_done, start_q.size(), frame_q.size());
        end
        n_checks++;
        if ({bus.overrun_err, bus.timeout_err, bus.overrun_cnt, bus_sat.overrun_cnt} !==
            {err_model, tmo_model, OVR_W'(cnt_model), SAT_W'(cnt2_model)}) begin
            n_fail++;
            $display("FAIL %s errors_after: got ovr=%b tmo=%b cnt=%0d sat=%0d want ovr=%b tmo=%b cnt=%0d sat=%0d",
                     tag, bus.overrun_err, bus.timeout_err, bus.overrun_cnt, bus_sat.overrun_cnt,
                     err_model, tmo_model, cnt_model, cnt2_model);
        end
        start_q.delete();
        frame_q.delete();
    endtask

    task automatic test_reset();
        bus.sample_en = 1'b0;
        bus.eng_done  = 1'b0;
        bus.clear_err = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (3) tick();
        n_checks++;
        if ({bus.eng_start, bus.eng_ch, bus.busy, bus.frame_done, bus.overrun_err, bus.timeout_err,
             bus.overrun_cnt, bus_sat.busy, bus_sat.overrun_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got start=%b ch=%0d busy=%b done=%b ovr=%b tmo=%b cnt=%0d want all 0",
                     bus.eng_start, bus.eng_ch, bus.busy, bus.frame_done, bus.overrun_err, bus.timeout_err,
                     bus.overrun_cnt);
        end
        reset = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({bus.eng_start, bus.busy, bus.frame_done, bus.overrun_err, bus.timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got start=%b busy=%b done=%b ovr=%b tmo=%b want all 0",
                     bus.eng_start, bus.busy, bus.frame_done, bus.overrun_err, bus.timeout_err);
        end
    endtask

    task automatic test_basic_frame();
        run_frame("basic", 1, 0, 0, 0);
    endtask

    task automatic test_delayed_done();
        run_frame("delayed_done", 10, 0, 0, 0);
    endtask

    task automatic test_done_at_timeout();
        run_frame("done_at_timeout", TIMEOUT, 0, 0, 0);
    endtask

    task automatic test_timeout();
        run_frame("timeout", -1, 0, 0, 0);
    endtask

    task automatic test_overrun();
        run_frame("overrun", 10, 2, 3, 0);
        // Second batch: last WAIT cycle and the DONE cycle; pushes the 2-bit counter into saturation.
        run_frame("overrun_sat", 10, 22, 2, 0);
    endtask

    task automatic test_clear_vs_overrun();
        run_frame("clear_vs_overrun", 1, 3, 1, 3);
    endtask

    task automatic test_clear_alone();
        bus.clear_err = 1'b1;
        model_drive(1'b0, 1'b1);
        tick();
        bus.clear_err = 1'b0;
        n_checks++;
        if ({bus.overrun_err, bus.timeout_err, bus.overrun_cnt, bus_sat.overrun_cnt} !==
            {err_model, tmo_model, OVR_W'(cnt_model), SAT_W'(cnt2_model)}) begin
            n_fail++;
            $display("FAIL clear_alone: got ovr=%b tmo=%b cnt=%0d sat=%0d want ovr=%b tmo=%b cnt=%0d sat=%0d",
                     bus.overrun_err, bus.timeout_err, bus.overrun_cnt, bus_sat.overrun_cnt,
                     err_model, tmo_model, cnt_model, cnt2_model);
        end
    endtask

    task automatic test_done_outside_wait();
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        tick();
        n_checks++;
        if ({bus.eng_start, bus.busy, bus.frame_done, bus.overrun_err, bus.timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL done_in_idle: got start=%b busy=%b done=%b ovr=%b tmo=%b want all 0",
                     bus.eng_start, bus.busy, bus.frame_done, bus.overrun_err, bus.timeout_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        bus.sample_en = 1'b1;
        tick();
        bus.sample_en = 1'b0;
        tick();
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.eng_ch !== CH_W'(1)) begin
            n_fail++;
            $display("FAIL pre_reset_wait_ch1: got busy=%b ch=%0d want busy=1 ch=1", bus.busy, bus.eng_ch);
        end
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({bus.eng_start, bus.eng_ch, bus.busy, bus.frame_done, bus.overrun_err, bus.timeout_err,
             bus.overrun_cnt, bus_sat.busy, bus_sat.eng_ch} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got start=%b ch=%0d busy=%b done=%b want all 0",
                     bus.eng_start, bus.eng_ch, bus.busy, bus.frame_done);
        end
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL no_stale_frame: idle cycle %0d got done=%b busy=%b want 0 0",
                         i, bus.frame_done, bus.busy);
            end
        end
        run_frame("after_reset", 1, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_delayed_done();
        test_done_at_timeout();
        test_timeout();
        test_overrun();
        test_clear_vs_overrun();
        test_clear_alone();
        test_done_outside_wait();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_engine_scheduler.md
Name: audio_engine_scheduler

Overview:
Sequences one shared per-sample audio processing engine across NUM_CH channels. Each accepted audio-frame strobe issues one start/done handshake per channel, in index order.
- Sits between the audio frame-enable source and the shared engine.
- Signals frame completion and flags overruns and engine hangs.
- Replaces fixed clock-delay alignment of enables with handshake-driven sequencing.

Parameters:
NUM_CH, 2, number of channels sequenced per frame (>=1)
CH_W, 1, width of channel index; must satisfy 2**CH_W >= NUM_CH
TIMEOUT, 64, max cycles to wait for eng_done per channel (>=2)
TMR_W, 7, timer width; must satisfy 2**TMR_W > TIMEOUT
OVR_W, 8, width of saturating overrun counter

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
sample_en  in  1  one-cycle audio frame strobe
eng_done  in  1  engine completion pulse for the current channel
clear_err  in  1  clears sticky flags and overrun counter
eng_start  out  1  one-cycle start pulse to engine
eng_ch  out  CH_W  channel index for current job; stable from eng_start until advance
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse after last channel completes
overrun_err  out  1  sticky: sample_en arrived while not IDLE
timeout_err  out  1  sticky: an engine job exceeded TIMEOUT
overrun_cnt  out  OVR_W  saturating count of dropped sample_en strobes

Behaviour:
- Reset values (asynchronous): state=IDLE, eng_ch=0, timer=0, all outputs 0.
- Outputs are decoded from registered state or are registers; there is no combinational path from any input to any output.

State machine (IDLE, START, WAIT, DONE):
- IDLE: sample_en=1 -> START, ch=0.
- START: eng_start=1 for exactly this cycle; timer<=0 -> WAIT. eng_done sampled in START is ignored.
- WAIT: timer increments each cycle.
  - eng_done=1 -> advance.
  - Else timer==TIMEOUT-1 -> set timeout_err, then advance (job abandoned).
  - Advance rule: ch==NUM_CH-1 -> DONE; else ch<=ch+1 -> START.
- DONE: frame_done=1 for this cycle -> IDLE.

Latency and handshake:
- sample_en sampled at edge t -> eng_start high in cycle t+1.
- Best case, with eng_done in the first WAIT cycle: 2 cycles per channel plus 1 DONE cycle. Frame = 2*NUM_CH+1 cycles; NUM_CH=2 gives 5.
- eng_done outside WAIT is ignored and raises no error.

Overrun:
- sample_en in any non-IDLE state (including DONE) is dropped.
- A dropped strobe sets overrun_err and increments overrun_cnt; the counter saturates at 2**OVR_W-1 with no wrap.

Error clearing:
- clear_err clears overrun_err, timeout_err and overrun_cnt.
- A new error event in the same cycle wins: the flag stays or is set, and the counter loads 1.
- clear_err does not disturb the sequence in progress.

Other boundaries:
- Timeout and eng_done in the same cycle: treated as done, no error.
- NUM_CH=1: ch stays 0; START -> WAIT -> DONE.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0. The partial frame is abandoned and no frame_done is produced.

Decomposition:
- Shared package: state encoding localparams (IDLE=0, START=1, WAIT=2, DONE=3) and the parameter legality checks (CH_W, TMR_W vs TIMEOUT).
- One natural sub-module, sched_timeout_timer: clear / count / expire output at TIMEOUT-1. It is instantiated once by the FSM.
- The saturating counter and sticky flags stay inline.

Test Plan:
- Reset, then sample_en pulse, eng_done returned 1 cycle after each eng_start (NUM_CH=2) -> eng_start in cycles 1 and 3 with eng_ch=0 then 1; frame_done in cycle 5; busy high in cycles 1-4 and 5; no errors.
- eng_done delayed 10 cycles per channel -> eng_ch holds each value for 11 cycles; frame_done exactly once; timeout_err=0.
- eng_done never asserted, TIMEOUT=64 -> each channel abandoned after 64 WAIT cycles; timeout_err=1; frame_done at cycle 1+2*(1+64)=131.
- sample_en repeated 3 times during a frame -> overrun_err=1, overrun_cnt=3; frame completes normally. With OVR_W=2 and 5 overruns -> overrun_cnt=3.
- clear_err in the same cycle as a dropped sample_en -> overrun_err stays 1, overrun_cnt=1; clear_err alone afterwards -> both 0.
- Reset asserted during WAIT of ch 1 -> outputs 0 immediately. A subsequent sample_en starts at eng_ch=0 and yields no stale frame_done.
